system_gpio_pio: RTL and testbench

SYSTEM_GPIO_PIO -- requirements
Module: system_gpio_pio

---
 rtl/system_gpio_pio.sv | 123 ++++++++++++
 tb/tb_system_gpio_pio.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/system_gpio_pio.sv
// system_gpio_pio: memory-mapped GPIO block with an output register (DATA, OUTSET,
// OUTCLEAR), a two-flop synchronized input view (INPUT) and, when the macro
// SYSTEM_GPIO_PIO_IRQ_EN is defined, per-bit edge capture (EDGECAP) gated by
// IRQMASK onto a level interrupt. Without the macro the edge/IRQ logic is absent,
// offsets 2 and 3 read 0 and irq is tied low.
module system_gpio_pio #(
    parameter int unsigned      WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_INPUT    = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK  = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP  = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign wdata        = writedata[WIDTH-1:0];
    // Bits above WIDTH are deliberately dropped on every register.
    assign unused_wdata = ^writedata;
    assign out_port     = data_reg;

    // Output register: direct load, set-bits and clear-bits views.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg <= RESET_VALUE;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:     data_reg <= wdata;
                ADDR_OUTSET:   data_reg <= data_reg | wdata;
                ADDR_OUTCLEAR: data_reg <= data_reg & ~wdata;
                default:       data_reg <= data_reg;
            endcase
        end
    end

    // Two-flop synchronizer for the asynchronous external inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

`ifdef SYSTEM_GPIO_PIO_IRQ_EN
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] cap_clr;

    // Edge detection between the synchronized value and its one-cycle-old copy.
    always_comb begin
        edge_det = '0;
        if (EDGE_TYPE == 0) begin
            edge_det = sync2 & ~prev;
        end else if (EDGE_TYPE == 1) begin
            edge_det = ~sync2 & prev;
        end else begin
            edge_det = sync2 ^ prev;
        end
    end

    assign cap_clr = (wr_en && (address == ADDR_EDGECAP)) ? wdata : '0;

    // Delay flop, mask register and edge capture; a new edge wins over a clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev     <= '0;
            irq_mask <= '0;
            edge_cap <= '0;
        end else begin
            prev     <= sync2;
            edge_cap <= (edge_cap & ~cap_clr) | edge_det;
            if (wr_en && (address == ADDR_IRQMASK)) begin
                irq_mask <= wdata;
            end
        end
    end

    assign irq = |(edge_cap & irq_mask);
`else
    assign irq = 1'b0;
`endif

    // Combinational read mux; write-only and undefined offsets read 0.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata = 32'(data_reg);
            ADDR_INPUT:   readdata = 32'(sync2);
`ifdef SYSTEM_GPIO_PIO_IRQ_EN
            ADDR_IRQMASK: readdata = 32'(irq_mask);
            ADDR_EDGECAP: readdata = 32'(edge_cap);
`endif
            default:      readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_system_gpio_pio.sv
// Self-checking bench for system_gpio_pio: three instances (16-bit rising,
// 8-bit any-edge, 32-bit falling) share one bus and are compared against a
// history-based reference model of the register map.
`timescale 1ns/1ps
module tb_system_gpio_pio;

`ifdef SYSTEM_GPIO_PIO_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    localparam logic [31:0] MSK [3] = '{32'h0000FFFF, 32'h000000FF, 32'hFFFFFFFF};
    localparam logic [31:0] RV  [3] = '{32'h0000A5A5, 32'h0000005A, 32'hDEADBEEF};
    localparam int          ET  [3] = '{0, 2, 1};

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] rd0, rd1, rd2;
    logic [15:0] in0, out0;
    logic [7:0]  in1, out1;
    logic [31:0] in2, out2;
    logic        irq0, irq1, irq2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (values masked to each instance's width).
    logic [31:0] m_out  [3];
    logic [31:0] m_mask [3];
    logic [31:0] m_cap  [3];
    logic [31:0] m_hist [3][3];   // [0]=last sampled in_port, [1]=one before, [2]=two before

    always #5 clk = ~clk;

    system_gpio_pio #(.WIDTH(16), .RESET_VALUE(16'hA5A5), .EDGE_TYPE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0),
        .in_port(in0), .out_port(out0), .irq(irq0));

    system_gpio_pio #(.WIDTH(8), .RESET_VALUE(8'h5A), .EDGE_TYPE(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd1),
        .in_port(in1), .out_port(out1), .irq(irq1));

    system_gpio_pio #(.WIDTH(32), .RESET_VALUE(32'hDEADBEEF), .EDGE_TYPE(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd2),
        .in_port(in2), .out_port(out2), .irq(irq2));

    function automatic logic [31:0] cur_in(int i);
        case (i)
            0:       return 32'(in0);
            1:       return 32'(in1);
            default: return in2;
        endcase
    endfunction

    function automatic logic [31:0] obs_rd(int i);
        case (i)
            0:       return rd0;
            1:       return rd1;
            default: return rd2;
        endcase
    endfunction

    function automatic logic [31:0] obs_out(int i);
        case (i)
            0:       return 32'(out0);
            1:       return 32'(out1);
            default: return out2;
        endcase
    endfunction

    function automatic logic obs_irq(int i);
        case (i)
            0:       return irq0;
            1:       return irq1;
            default: return irq2;
        endcase
    endfunction

    // Expected register read for instance i at offset a.
    function automatic logic [31:0] model_read(int i, logic [2:0] a);
        case (a)
            3'd0:    return m_out[i];
            3'd1:    return m_hist[i][1];
            3'd2:    return IRQ_EN ? m_mask[i] : 32'h0;
            3'd3:    return IRQ_EN ? m_cap[i] : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic model_irq(int i);
        return IRQ_EN && ((m_cap[i] & m_mask[i]) != 32'h0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_out[i]  = RV[i];
            m_mask[i] = '0;
            m_cap[i]  = '0;
            for (int k = 0; k < 3; k++) m_hist[i][k] = '0;
        end
    endtask

    // One clock: model advances on posedge using the bus as driven; returns at negedge.
    task automatic tick();
        logic        wr;
        logic [31:0] d, nw, od, det, clr;
        @(posedge clk);
        wr = chipselect && !write_n;
        for (int i = 0; i < 3; i++) begin
            d   = writedata & MSK[i];
            nw  = m_hist[i][1];
            od  = m_hist[i][2];
            det = (ET[i] == 0) ? (nw & ~od) : (ET[i] == 1) ? (~nw & od & MSK[i]) : (nw ^ od);
            clr = (wr && address == 3'd3) ? d : 32'h0;
            if (IRQ_EN) m_cap[i] = (m_cap[i] & ~clr) | det;
            if (wr) begin
                case (address)
                    3'd0: m_out[i] = d;
                    3'd2: if (IRQ_EN) m_mask[i] = d;
                    3'd4: m_out[i] = m_out[i] | d;
                    3'd5: m_out[i] = m_out[i] & ~d;
                    default: ;
                endcase
            end
            m_hist[i][2] = m_hist[i][1];
            m_hist[i][1] = m_hist[i][0];
            m_hist[i][0] = cur_in(i) & MSK[i];
        end
        @(negedge clk);
    endtask

    task automatic bus_write(logic [2:0] a, logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = $urandom;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd0;
        writedata = 32'hFFFFFFFF; in0 = '0; in1 = '0; in2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (out0 !== 16'hA5A5) begin n_fail++; $display("FAIL reset_out0: got %h want a5a5", out0); end
        n_checks++;
        if (rd0 !== 32'h0000A5A5) begin n_fail++; $display("FAIL reset_rd0: got %h want 0000a5a5", rd0); end
        n_checks++;
        if (out1 !== 8'h5A || out2 !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL reset_out12: got %h %h want 5a deadbeef", out1, out2);
        end
        n_checks++;
        if (irq0 !== 1'b0 || irq1 !== 1'b0 || irq2 !== 1'b0) begin
            n_fail++; $display("FAIL reset_irq: got %b%b%b want 000", irq0, irq1, irq2);
        end
        address = 3'd3;
        #1;
        n_checks++;
        if (rd0 !== 32'h0 || rd2 !== 32'h0) begin n_fail++; $display("FAIL reset_edgecap: got %h %h want 0", rd0, rd2); end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        address = 3'd0;
        tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs_out(i) !== m_out[i] || obs_irq(i) !== 1'b0) begin
                n_fail++; $display("FAIL post_reset[%0d]: got %h/%b want %h/0", i, obs_out(i), obs_irq(i), m_out[i]);
            end
        end
    endtask

    task automatic test_data_regs();
        logic [15:0] exp_seq [3] = '{16'h1234, 16'h12F4, 16'h10F0};
        logic [2:0]  a_seq   [3] = '{3'd0, 3'd4, 3'd5};
        logic [31:0] d_seq   [3] = '{32'hFFFF1234, 32'h000000F0, 32'h00000204};
        for (int s = 0; s < 3; s++) begin
            bus_write(a_seq[s], d_seq[s]);
            address = 3'd0;
            #1;
            n_checks++;
            if (out0 !== exp_seq[s] || rd0 !== 32'(exp_seq[s])) begin
                n_fail++; $display("FAIL data_seq%0d: got %h/%h want %h", s, out0, rd0, exp_seq[s]);
            end
            n_checks++;
            if (out1 !== m_out[1][7:0] || out2 !== m_out[2]) begin
                n_fail++; $display("FAIL data_seq%0d_w: got %h %h want %h %h", s, out1, out2, m_out[1], m_out[2]);
            end
        end
        address = 3'd4;
        #1;
        n_checks++;
        if (rd0 !== 32'h0) begin n_fail++; $display("FAIL outset_read: got %h want 0", rd0); end
    endtask

    task automatic test_input_edge();
        bus_write(3'd2, 32'h00000001);
        repeat (3) tick();
        in0 = 16'h0001;
        address = 3'd1;
        tick();
        n_checks++;
        if (rd0 !== 32'h0) begin n_fail++; $display("FAIL input_lat1: got %h want 0", rd0); end
        tick();
        n_checks++;
        if (rd0 !== 32'h1) begin n_fail++; $display("FAIL input_lat2: got %h want 00000001", rd0); end
        address = 3'd3;
        #1;
        n_checks++;
        if (rd0 !== 32'h0 || irq0 !== 1'b0) begin n_fail++; $display("FAIL edge_early: got %h/%b want 0/0", rd0, irq0); end
        tick();
        n_checks++;
        if (rd0 !== (IRQ_EN ? 32'h1 : 32'h0) || irq0 !== IRQ_EN) begin
            n_fail++; $display("FAIL edge_cap: got %h/%b want %h/%b", rd0, irq0, IRQ_EN ? 32'h1 : 32'h0, IRQ_EN);
        end
    endtask

    task automatic test_set_over_clear();
        in0 = 16'h0000;
        repeat (3) tick();
        in0 = 16'h0001;
        tick();
        tick();
        bus_write(3'd3, 32'h00000001);
        address = 3'd3;
        #1;
        n_checks++;
        if (rd0 !== (IRQ_EN ? 32'h1 : 32'h0) || irq0 !== IRQ_EN) begin
            n_fail++; $display("FAIL set_over_clear: got %h/%b want %h/%b", rd0, irq0, IRQ_EN ? 32'h1 : 32'h0, IRQ_EN);
        end
        bus_write(3'd3, 32'h00000001);
        address = 3'd3;
        #1;
        n_checks++;
        if (rd0 !== 32'h0 || irq0 !== 1'b0) begin n_fail++; $display("FAIL w1c: got %h/%b want 0/0", rd0, irq0); end
    endtask

    task automatic test_width8();
        bus_write(3'd0, 32'hFFFFFFFF);
        address = 3'd0;
        #1;
        n_checks++;
        if (rd1 !== 32'h000000FF || rd0 !== 32'h0000FFFF || rd2 !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL width_trunc: got %h %h %h", rd1, rd0, rd2);
        end
        bus_write(3'd3, 32'hFFFFFFFF);
        for (int pass = 0; pass < 2; pass++) begin
            in1 = (pass == 0) ? 8'h08 : 8'h00;
            repeat (3) tick();
            address = 3'd3;
            #1;
            n_checks++;
            if (rd1 !== (IRQ_EN ? 32'h08 : 32'h0)) begin
                n_fail++; $display("FAIL any_edge%0d: got %h want %h", pass, rd1, IRQ_EN ? 32'h08 : 32'h0);
            end
            bus_write(3'd3, 32'h00000008);
        end
    endtask

    task automatic test_masked_regs();
        bus_write(3'd2, 32'hFFFFFFFF);
        for (int c = 0; c < 12; c++) begin
            in0 = 16'($urandom); in1 = 8'($urandom); in2 = $urandom;
            tick();
            for (int a = 2; a < 4; a++) begin
                address = 3'(a);
                #1;
                for (int i = 0; i < 3; i++) begin
                    n_checks++;
                    if (obs_rd(i) !== model_read(i, address) || obs_irq(i) !== model_irq(i)) begin
                        n_fail++; $display("FAIL masked_regs[%0d] a%0d: got %h/%b want %h/%b",
                            i, a, obs_rd(i), obs_irq(i), model_read(i, address), model_irq(i));
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(3) == 0) in0 = 16'($urandom);
            if ($urandom_range(3) == 0) in1 = 8'($urandom);
            if ($urandom_range(3) == 0) in2 = $urandom;
            chipselect = 1'($urandom);
            write_n    = 1'($urandom);
            address    = 3'($urandom);
            writedata  = $urandom;
            #1;
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs_rd(i) !== model_read(i, address) || obs_out(i) !== m_out[i] || obs_irq(i) !== model_irq(i)) begin
                    n_fail++; $display("FAIL random[%0d] c%0d a%0d: got %h/%h/%b want %h/%h/%b", i, c, address,
                        obs_rd(i), obs_out(i), obs_irq(i), model_read(i, address), m_out[i], model_irq(i));
                end
            end
            tick();
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic test_mid_reset();
        bus_write(3'd2, 32'hFFFFFFFF);
        bus_write(3'd0, 32'h13572468);
        in0 = ~in0; in1 = ~in1; in2 = ~in2;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (out0 !== 16'hA5A5 || out1 !== 8'h5A || out2 !== 32'hDEADBEEF || irq0 !== 1'b0 || irq1 !== 1'b0 || irq2 !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got %h %h %h %b%b%b", out0, out1, out2, irq0, irq1, irq2);
        end
        in0 = '0; in1 = '0; in2 = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        address = 3'd3;
        for (int c = 0; c < 4; c++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs_rd(i) !== 32'h0 || obs_irq(i) !== 1'b0) begin
                    n_fail++; $display("FAIL post_reset_edge[%0d] c%0d: got %h/%b want 0/0", i, c, obs_rd(i), obs_irq(i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_data_regs();
        test_input_edge();
        test_set_over_clear();
        test_width8();
        test_masked_regs();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
